// File: rtl/uartrx_frame_ctrl.sv
// UART RX packet framer: hunts for SYNC_BYTE, gathers NUM_BYTES payload bytes, and offers them on a valid/ready port.
// Define UARTRX_FRAME_TIMEOUT_EN to build the inter-byte idle timeout that drives sync_lost_o.
module uartrx_frame_ctrl #(
  parameter int unsigned NUM_BYTES      = 108,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 52080
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  input  logic                   byte_ferr_i,
  output logic                   pkt_valid_o,
  input  logic                   pkt_ready_i,
  output logic [8*NUM_BYTES-1:0] pkt_data_o,
  output logic                   pkt_err_o,
  output logic                   busy_o,
  output logic [7:0]             drop_count_o,
  output logic                   sync_lost_o
);

  localparam int unsigned      IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_COLLECT, S_HOLD} state_e;

  state_e                   state_q;
  logic [NUM_BYTES-1:0][7:0] slot_q;
  logic [NUM_BYTES-1:0][7:0] slot_d;
  logic [IDX_W-1:0]         idx_q;
  logic [8*NUM_BYTES-1:0]   pkt_data_q;
  logic                     pkt_valid_q;
  logic                     pkt_err_q;
  logic                     busy_q;
  logic [7:0]               drop_count_q;
  logic                     sync_lost_q;
  logic                     is_sync;
`ifdef UARTRX_FRAME_TIMEOUT_EN
  logic [16:0]              to_q;
`endif

  assign is_sync = byte_valid_i && (byte_data_i == SYNC_BYTE) && !byte_ferr_i;

  // Slot array with the current byte merged in, so the last byte reaches pkt_data in the same edge.
  always_comb begin
    slot_d        = slot_q;
    slot_d[idx_q] = byte_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      idx_q        <= '0;
      pkt_data_q   <= '0;
      pkt_valid_q  <= 1'b0;
      pkt_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      drop_count_q <= '0;
      sync_lost_q  <= 1'b0;
`ifdef UARTRX_FRAME_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      sync_lost_q <= 1'b0;
`ifdef UARTRX_FRAME_TIMEOUT_EN
      to_q        <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (enable_i) state_q <= S_HUNT;
        end
        S_HUNT: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
          end else if (is_sync) begin
            state_q   <= S_COLLECT;
            idx_q     <= '0;
            pkt_err_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_COLLECT: begin
          // A falling enable beats a simultaneous final byte: the partial packet is dropped.
          if (!enable_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (byte_valid_i) begin
            slot_q    <= slot_d;
            pkt_err_q <= pkt_err_q | byte_ferr_i;
            if (idx_q == LAST_IDX) begin
              pkt_data_q  <= slot_d;
              pkt_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
`ifdef UARTRX_FRAME_TIMEOUT_EN
          else if (to_q == 17'(TIMEOUT_CYCLES - 1)) begin
            sync_lost_q <= 1'b1;
            state_q     <= S_HUNT;
            busy_q      <= 1'b0;
          end else begin
            to_q <= to_q + 17'd1;
          end
`endif
        end
        S_HOLD: begin
          if (byte_valid_i && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
          if (pkt_ready_i) begin
            pkt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= enable_i ? S_HUNT : S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_valid_o  = pkt_valid_q;
  assign pkt_data_o   = pkt_data_q;
  assign pkt_err_o    = pkt_err_q;
  assign busy_o       = busy_q;
  assign drop_count_o = drop_count_q;
  assign sync_lost_o  = sync_lost_q;

endmodule

// File: tb/tb_uartrx_frame_ctrl.sv
// Directed bench for uartrx_frame_ctrl (NUM_BYTES=4, TIMEOUT_CYCLES=20); packets are scoreboarded on the handshake.
module tb_uartrx_frame_ctrl;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst, enable, byte_valid, byte_ferr, pkt_ready;
  logic [7:0]    byte_data;
  logic          pkt_valid, pkt_err, busy, sync_lost;
  logic [8*NB-1:0] pkt_data;
  logic [7:0]    drop_count;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];

  uartrx_frame_ctrl #(.NUM_BYTES(NB), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(20)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .byte_valid_i(byte_valid),
    .byte_data_i(byte_data), .byte_ferr_i(byte_ferr), .pkt_valid_o(pkt_valid),
    .pkt_ready_i(pkt_ready), .pkt_data_o(pkt_data), .pkt_err_o(pkt_err),
    .busy_o(busy), .drop_count_o(drop_count), .sync_lost_o(sync_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted packet must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && pkt_valid && pkt_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pkt", {pkt_err, pkt_data[30:0]}, 32'hxxxxxxxx);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("pkt_data", pkt_data, e[31:0]);
        check("pkt_err", 32'(pkt_err), 32'(e[32]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_ferr  = f;
    tick();
    byte_valid = 1'b0;
    byte_ferr  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(pkt_valid), 32'd0);
    check({tag, "_data"}, pkt_data, 32'd0);
    check({tag, "_err"}, 32'(pkt_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_drop"}, 32'(drop_count), 32'd0);
    check({tag, "_sync_lost"}, 32'(sync_lost), 32'd0);
  endtask

  initial begin
    int pulses;
    int pulse_at;
    rst = 1'b1; enable = 1'b0; byte_valid = 1'b0; byte_ferr = 1'b0;
    byte_data = 8'h00; pkt_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // IDLE ignores bytes
    send(8'hA5, 1'b0);
    check("idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();

    // 1: sync hunt, first packet, 1-cycle latency
    send(8'h11, 1'b0);
    check("hunt_busy", 32'(busy), 32'd0);
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    check("pre_final_valid", 32'(pkt_valid), 32'd0);
    sb.push_back({1'b0, 32'h04030201});
    send(8'h04, 1'b0);
    check("t1_valid", 32'(pkt_valid), 32'd1);
    check("t1_data", pkt_data, 32'h04030201);
    check("t1_busy", 32'(busy), 32'd1);

    // 2: back-pressure with dropped bytes
    for (int i = 0; i < 10; i++) begin
      byte_valid = (i % 3 == 0) && (i < 9);
      byte_data  = 8'h55;
      tick();
      byte_valid = 1'b0;
      check("hold_stable", pkt_data, 32'h04030201);
    end
    check("t2_drop", 32'(drop_count), 32'd3);
    pkt_ready = 1'b1;
    tick();
    check("t2_valid_clr", 32'(pkt_valid), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // 3: framing error tagging; ferr sync is ignored
    sb.push_back({1'b1, 32'h40302010});
    send(8'hA5, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b1); send(8'h30, 1'b0); send(8'h40, 1'b0);
    check("t3_valid", 32'(pkt_valid), 32'd1);
    check("t3_err", 32'(pkt_err), 32'd1);
    tick();
    send(8'hA5, 1'b1);
    check("t3_ferr_sync", 32'(busy), 32'd0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    check("t3_no_pkt", 32'(pkt_valid), 32'd0);

    // 4: enable drop mid-packet, then clean restart
    send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
    enable = 1'b0;
    tick();
    check("t4_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    sb.push_back({1'b0, 32'h08070605});
    send(8'hA5, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b0);
    check("t4_data", pkt_data, 32'h08070605);
    tick();

    // enable fall coincident with final byte: byte lost, back to IDLE
    send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    enable = 1'b0;
    send(8'h04, 1'b0);
    check("race_valid", 32'(pkt_valid), 32'd0);
    check("race_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();

    // 5: inter-byte timeout
    send(8'hA5, 1'b0); send(8'h01, 1'b0);
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (sync_lost) begin
        pulses++;
        pulse_at = i;
      end
    end
`ifdef UARTRX_FRAME_TIMEOUT_EN
    check("t5_pulses", 32'(pulses), 32'd1);
    check("t5_pulse_at", 32'(pulse_at), 32'd20);
    check("t5_busy", 32'(busy), 32'd0);
`else
    check("t5_pulses", 32'(pulses), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
`endif
    sb.push_back({1'b0, 32'h0D0C0B0A});
    send(8'hA5, 1'b0); send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'h0D, 1'b0);
    check("t5_data", pkt_data, 32'h0D0C0B0A);
    tick();

    // 6: drop_count saturation, then reset mid-COLLECT
    pkt_ready = 1'b0;
    sb.push_back({1'b0, 32'h44332211});
    send(8'hA5, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    for (int i = 0; i < 260; i++) tick();
    byte_valid = 1'b0;
    check("t6_drop_sat", 32'(drop_count), 32'd255);
    pkt_ready = 1'b1;
    tick();
    check("t6_valid_clr", 32'(pkt_valid), 32'd0);
    send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b1);
    check("t6_err_pre", 32'(pkt_err), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
